// File: rtl/fetch_sequencer_if.sv
// Fetch bus between the sequencer, the instruction ROM and decode.
// master: fetch_sequencer side; slave: ROM/decode side.
interface fetch_sequencer_if;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        Halt;
  logic [31:0] MemAddr;
  logic [31:0] MemInstr;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic        InstrValid;

  modport master (
    input  Stall,
    input  Redirect,
    input  RedirectPC,
    input  Halt,
    input  MemInstr,
    output MemAddr,
    output Instr,
    output InstrPC,
    output InstrValid
  );

  modport slave (
    output Stall,
    output Redirect,
    output RedirectPC,
    output Halt,
    output MemInstr,
    input  MemAddr,
    input  Instr,
    input  InstrPC,
    input  InstrValid
  );
endinterface

// File: rtl/fetch_sequencer.sv
// PC owner and sync-ROM fetch sequencer for the single-cycle MIPS core.
// FETCH_PERF_EN adds saturating FetchCount/StallCount outputs.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic CLK,
  input  logic RST_N,
  fetch_sequencer_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] FetchCount,
  output logic [31:0] StallCount
`endif
);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [31:0] RST_PC = {RESET_PC[31:2], 2'b00};

  state_t      state, state_n;
  logic [31:0] fetch_pc, fetch_n;
  logic [31:0] req_pc, req_n;
  logic [31:0] mem_pc, tgt;
  logic        valid, valid_n;
  logic        sel_redir, sel_halt, sel_idle;
  logic        sel_fill, sel_hold, sel_adv;
  logic        quiet;
  logic        unused_ok;

  assign tgt   = {bus.RedirectPC[31:2], 2'b00};
  assign quiet = !bus.Redirect && !bus.Halt;

  // One-hot priority decode: Redirect > Halt > state/Stall
  assign sel_redir = bus.Redirect;
  assign sel_halt  = !bus.Redirect && bus.Halt;
  assign sel_idle  = quiet && (state == HALT);
  assign sel_fill  = quiet && (state == FILL);
  assign sel_hold  = quiet && (state == RUN) && bus.Stall && valid;
  assign sel_adv   = quiet && (state == RUN) && !(bus.Stall && valid);

  always_comb begin
    state_n = state;
    fetch_n = fetch_pc;
    req_n   = req_pc;
    valid_n = valid;
    mem_pc  = fetch_pc;
    unique case (1'b1)
      sel_redir: begin
        mem_pc  = tgt;
        req_n   = tgt;
        fetch_n = tgt + 32'd4;
        state_n = RUN;
        valid_n = 1'b1;
      end
      sel_halt: begin
        mem_pc  = req_pc;
        state_n = HALT;
        valid_n = 1'b0;
      end
      sel_idle: begin
        mem_pc  = req_pc;
        valid_n = 1'b0;
      end
      sel_fill: begin
        mem_pc  = fetch_pc;
        req_n   = fetch_pc;
        fetch_n = fetch_pc + 32'd4;
        state_n = RUN;
        valid_n = 1'b1;
      end
      sel_hold: begin
        mem_pc  = req_pc;
      end
      sel_adv: begin
        mem_pc  = fetch_pc;
        req_n   = fetch_pc;
        fetch_n = fetch_pc + 32'd4;
        valid_n = 1'b1;
      end
      default: begin
        mem_pc  = req_pc;
        state_n = FILL;
        valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= FILL;
      fetch_pc <= RST_PC;
      req_pc   <= RST_PC;
      valid    <= 1'b0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_n;
      req_pc   <= req_n;
      valid    <= valid_n;
    end
  end

  assign bus.MemAddr    = {2'b00, mem_pc[31:2]};
  assign bus.Instr      = bus.MemInstr;
  assign bus.InstrPC    = req_pc;
  assign bus.InstrValid = valid;
  assign unused_ok      = ^{mem_pc[1:0], bus.RedirectPC[1:0]};

`ifdef FETCH_PERF_EN
  logic consume, stall_hit;

  assign consume   = valid && !bus.Stall && quiet;
  assign stall_hit = valid && bus.Stall;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      FetchCount <= 32'd0;
      StallCount <= 32'd0;
    end else begin
      if (consume && (FetchCount != 32'hFFFF_FFFF))
        FetchCount <= FetchCount + 32'd1;
      if (stall_hit && (StallCount != 32'hFFFF_FFFF))
        StallCount <= StallCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a PC-level reference model.
// Compile with +define+FETCH_PERF_EN to also check the counters.
module tb_fetch_sequencer;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  fetch_sequencer_if bus();

`ifdef FETCH_PERF_EN
  logic [31:0] FetchCount, StallCount;
`endif

  fetch_sequencer #(.RESET_PC(RESET_PC)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .bus(bus)
`ifdef FETCH_PERF_EN
    ,
    .FetchCount(FetchCount),
    .StallCount(StallCount)
`endif
  );

  logic [31:0] rom [0:63];
  int tests = 0;
  int fails = 0;

  // Synchronous-read ROM
  always @(posedge CLK) bus.MemInstr <= rom[bus.MemAddr[5:0]];

  // Model: PC of the presented word, whether it is valid, halted flag
  logic        m_valid = 1'b0;
  logic        m_halt  = 1'b0;
  logic [31:0] m_pc    = RESET_PC;
  logic [31:0] m_fc    = 32'd0;
  logic [31:0] m_sc    = 32'd0;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_valid <= 1'b0;
      m_halt  <= 1'b0;
      m_pc    <= RESET_PC;
      m_fc    <= 32'd0;
      m_sc    <= 32'd0;
    end else begin
      if (m_valid && bus.Stall && m_sc != 32'hFFFF_FFFF)
        m_sc <= m_sc + 1;
      if (m_valid && !bus.Stall && !bus.Redirect && !bus.Halt
          && m_fc != 32'hFFFF_FFFF)
        m_fc <= m_fc + 1;
      if (bus.Redirect) begin
        m_pc    <= bus.RedirectPC & 32'hFFFF_FFFC;
        m_valid <= 1'b1;
        m_halt  <= 1'b0;
      end else if (bus.Halt) begin
        m_valid <= 1'b0;
        m_halt  <= 1'b1;
      end else if (m_halt) begin
        m_valid <= 1'b0;
      end else if (!m_valid) begin
        m_valid <= 1'b1;
      end else if (!bus.Stall) begin
        m_pc <= m_pc + 32'd4;
      end
    end
  end

  // Word index the ROM must be reading for the next presented word
  function automatic logic [31:0] exp_addr();
    logic [31:0] pc;
    if (bus.Redirect) pc = bus.RedirectPC;
    else if (bus.Halt || m_halt) pc = m_pc;
    else if (!m_valid) pc = m_pc;
    else if (bus.Stall) pc = m_pc;
    else pc = m_pc + 32'd4;
    return pc >> 2;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    chk("valid", 32'(bus.InstrValid), 32'(m_valid));
    chk("memaddr", bus.MemAddr, exp_addr());
    chk("instr_pc", bus.InstrPC, m_pc);
    if (m_valid) chk("instr", bus.Instr, rom[m_pc[7:2]]);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'hAC00_0000 | 32'(i);
    rom[0] = 32'h2008_0004;
    rom[1] = 32'h2009_0003;
    rom[2] = 32'h0109_5025;
    bus.Stall = 1'b0;
    bus.Redirect = 1'b0;
    bus.RedirectPC = 32'h0;
    bus.Halt = 1'b0;

    #1;
    chk("rst_valid", 32'(bus.InstrValid), 32'd0);
    chk("rst_addr", bus.MemAddr, 32'd0);
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;

    step();
    chk("first_pc", bus.InstrPC, 32'h0);
    chk("first_instr", bus.Instr, 32'h2008_0004);
    step();
    chk("pc4", bus.InstrPC, 32'h4);

    for (int i = 0; i < 3; i++) begin
      bus.Stall = 1'b1;
      #1;
      chk("stall_addr", bus.MemAddr, 32'd1);
      chk("stall_instr", bus.Instr, 32'h2009_0003);
      step();
    end
    bus.Stall = 1'b0;
    step();
    chk("after_stall", bus.InstrPC, 32'h8);
    chk("after_stall_i", bus.Instr, 32'h0109_5025);

    bus.Redirect = 1'b1;
    bus.RedirectPC = 32'h30;
    #1;
    chk("redir_addr", bus.MemAddr, 32'hC);
    step();
    bus.Redirect = 1'b0;
    chk("redir_pc", bus.InstrPC, 32'h30);
    chk("redir_instr", bus.Instr, 32'hAC00_000C);
`ifdef FETCH_PERF_EN
    chk("fc_lit", FetchCount, 32'd2);
    chk("sc_lit", StallCount, 32'd3);
`endif
    step();
    chk("redir_next", bus.InstrPC, 32'h34);

    bus.Halt = 1'b1;
    step();
    bus.Halt = 1'b0;
    chk("halt_valid0", 32'(bus.InstrValid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      bus.Stall = (i % 2 == 0);
      #1;
      chk("halt_valid", 32'(bus.InstrValid), 32'd0);
      chk("halt_addr", bus.MemAddr, 32'hD);
      step();
    end
    bus.Stall = 1'b0;
    bus.Redirect = 1'b1;
    bus.RedirectPC = 32'h50;
    step();
    bus.Redirect = 1'b0;
    chk("resume_pc", bus.InstrPC, 32'h50);
    chk("resume_instr", bus.Instr, 32'hAC00_0014);

    bus.Redirect = 1'b1;
    bus.Halt = 1'b1;
    bus.Stall = 1'b1;
    bus.RedirectPC = 32'h13;
    step();
    bus.Redirect = 1'b0;
    bus.Halt = 1'b0;
    bus.Stall = 1'b0;
    chk("combo_pc", bus.InstrPC, 32'h10);
    chk("combo_valid", 32'(bus.InstrValid), 32'd1);

    bus.Redirect = 1'b1;
    bus.RedirectPC = 32'h20;
    step();
    bus.RedirectPC = 32'h28;
    step();
    bus.Redirect = 1'b0;
    chk("b2b_pc", bus.InstrPC, 32'h28);
    step();
    bus.Stall = 1'b1;
    step();
    bus.Stall = 1'b0;
    step();
`ifdef FETCH_PERF_EN
    chk("fc_model", FetchCount, m_fc);
    chk("sc_model", StallCount, m_sc);
`endif

    RST_N = 1'b0;
    #1;
    chk("async_valid", 32'(bus.InstrValid), 32'd0);
    chk("async_pc", bus.InstrPC, RESET_PC);
`ifdef FETCH_PERF_EN
    chk("fc_clear", FetchCount, 32'd0);
    chk("sc_clear", StallCount, 32'd0);
`endif
    step();
    RST_N = 1'b1;
    step();
    chk("restart_pc", bus.InstrPC, RESET_PC);
    chk("restart_valid", 32'(bus.InstrValid), 32'd1);

    bus.Redirect = 1'b1;
    bus.RedirectPC = 32'hFFFF_FFFC;
    step();
    bus.Redirect = 1'b0;
    chk("top_pc", bus.InstrPC, 32'hFFFF_FFFC);
    chk("top_instr", bus.Instr, 32'hAC00_003F);
    step();
    chk("wrap_pc", bus.InstrPC, 32'h0);
    chk("wrap_instr", bus.Instr, 32'h2008_0004);
    step();
`ifdef FETCH_PERF_EN
    chk("fc_end", FetchCount, m_fc);
    chk("sc_end", StallCount, m_sc);
`endif

    @(negedge CLK);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Sequences the synchronous-read instruction ROM (word-indexed `Address`, registered `Instr` one `CLK` after the address) for the single-cycle MIPS core.
- Owns the program counter and drives the ROM word address.
- Tracks the one-cycle read latency and presents each fetched word to decode with its PC and a valid flag.
- Handles decode back-pressure (stall), control-flow redirects (branch/jump) and halt, with no bubbles on sequential fetch, stall release or redirect.

## Interface
- `RESET_PC`, default 32'h0000_0000: byte PC fetched first after reset. Bits [1:0] are ignored.
- `CLK` input 1: single clock. All state updates on the rising edge.
- `RST_N` input 1: asynchronous, active-low reset.
- `Stall` input 1: decode cannot accept the presented word this cycle.
- `Redirect` input 1: one-cycle request to restart fetch at `RedirectPC`.
- `RedirectPC` input 32: byte target address. Bits [1:0] are ignored (treated as 00).
- `Halt` input 1: stop fetching. Only `Redirect` resumes fetch.
- `MemAddr` output 32: ROM word index, equal to {2'b00, pc[31:2]}. Combinational from state and inputs.
- `MemInstr` input 32: ROM registered read data, for the address presented on the previous cycle.
- `Instr` output 32: presented instruction. Passthrough of `MemInstr`.
- `InstrPC` output 32: byte PC of `Instr`. Registered.
- `InstrValid` output 1: `Instr`/`InstrPC` valid. Registered.

## Operation
- Registers:
  - FetchPC: next sequential byte PC.
  - ReqPC: byte PC of the word now on `MemInstr`, driven on `InstrPC`.
  - state ∈ {FILL, RUN, HALT}.
- Reset state: FetchPC=`RESET_PC`, ReqPC=`RESET_PC`, state=FILL.
- Output reset values:
  - `InstrValid`=0.
  - `InstrPC`=`RESET_PC`.
  - `MemAddr`=`RESET_PC`>>2.
  - `Instr` follows `MemInstr` and is don't-care while invalid.
- A word is consumed when `InstrValid`=1, `Stall`=0, `Redirect`=0 and `Halt`=0.
- Input priority is `Redirect` > `Halt` > `Stall`. This applies in every state.
- `Redirect`=1, any state:
  - `MemAddr`=`RedirectPC`>>2.
  - Next: ReqPC=`RedirectPC`&~3, FetchPC=ReqPC+4, state=RUN, `InstrValid`=1.
  - The word presented in the redirect cycle is discarded.
- `Halt`=1, no redirect:
  - `MemAddr`=ReqPC>>2.
  - Next: state=HALT, `InstrValid`=0. ReqPC and FetchPC are held.
- FILL:
  - `MemAddr`=FetchPC>>2.
  - Next: ReqPC=FetchPC, FetchPC+=4, state=RUN, `InstrValid`=1.
- RUN, hold case (`Stall`=1 and `InstrValid`=1):
  - `MemAddr`=ReqPC>>2, so the ROM re-reads the same word and `Instr` stays stable.
  - All registers are held.
- RUN, otherwise:
  - `MemAddr`=FetchPC>>2.
  - Next: ReqPC=FetchPC, FetchPC+=4, `InstrValid`=1.
- HALT:
  - `MemAddr`=ReqPC>>2, `InstrValid`=0, registers held.
  - `Stall` has no effect.
- PC arithmetic is 32-bit modulo 2^32. 32'hFFFF_FFFC+4 wraps to 0 with no flag.

## Timing
- Reset to first valid word:
  - The first `CLK` edge after `RST_N` rises moves FILL→RUN.
  - `InstrValid`=1 with `InstrPC`=`RESET_PC` after that edge.
- Sequential throughput is one word per cycle.
- Stall release costs zero bubbles. The word at ReqPC+4 is valid the cycle after the first cycle with `Stall`=0.
- Redirect latency is one cycle. The target word is valid on the cycle after `Redirect`.
- Back-to-back redirects: each one overrides the previous. The last target wins.
- Reset asserted mid-operation: all registers return to their reset values immediately (asynchronous). Any in-flight word is dropped.
- Combinational paths: `Stall`, `Redirect`, `RedirectPC`, `Halt` → `MemAddr`. Decode must drive these from registers or shallow logic.

## Configuration
- `FETCH_PERF_EN` defined: adds two outputs.
  - `FetchCount` output 32: counts consumed words.
  - `StallCount` output 32: counts cycles in which `Stall`=1 and `InstrValid`=1.
  - Both reset to 0 and saturate at 32'hFFFF_FFFF.
- `FETCH_PERF_EN` undefined: both ports and counters are absent. All other behaviour is identical.

## Test plan
- Reset release, `RESET_PC`=0, ROM[0..2]={ADDI 4, ADDI 3, OR}:
  - Required: `InstrPC`=0,4,8 on consecutive cycles with `InstrValid`=1 and `Instr` matching ROM[0..2].
- `Stall` held 3 cycles while `InstrPC`=4:
  - Required: `Instr`=ROM[1] stable and `MemAddr`=1 throughout.
  - Required: `InstrPC`=8 on the cycle after `Stall` drops.
- `Redirect` with `RedirectPC`=0x30 while `InstrPC`=8:
  - Required: next cycle `InstrPC`=0x30, `Instr`=ROM[12], then 0x34.
  - Required: the `InstrPC`=8 word is not counted as consumed.
- `Halt`, then `Stall` toggling, then `Redirect` with `RedirectPC`=0x50:
  - Required: `InstrValid`=0 from the cycle after `Halt` until the redirect.
  - Required: then `InstrPC`=0x50, `Instr`=ROM[20].
- `Redirect`+`Halt`+`Stall` in the same cycle, `RedirectPC`=0x13:
  - Required: next cycle `InstrPC`=0x10, `InstrValid`=1.
- `RST_N` dropped mid-run, and a redirect to 0xFFFF_FFFC:
  - Required for reset: `InstrValid`=0 immediately; after release, restart at `RESET_PC`.
  - Required for the redirect: next PC wraps to 0.
  - With `FETCH_PERF_EN`: counts match the number of consumed words and stall cycles, and counters clear on reset.
